// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling and a valid/ready
// byte handshake. Framing errors and overruns are flagged for the command FSM.
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   enable_i   receiver enable; low forces the FSM back to idle
//   in_i       asynchronous RX line, idles high
//   ready_i    consumer accepts the byte when valid_o & ready_i
//   out_o      last received byte
//   valid_o    unread byte available
//   error_o    sticky framing error, cleared by the next validated start bit
//   overrun_o  an unread byte was overwritten
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | waiting for a low level on the synchronized line
// START      | half-bit delay, then re-check the start bit
// DATA       | sample 8 data bits, one per bit time, LSB first
// STOP       | sample the stop bit and publish or flag the frame
// WAIT_HIGH  | framing error seen, wait for the line to release

module uart_receiver #(
    parameter int CLOCK_RATE = 24000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       in_i,
    input  logic       ready_i,
    output logic [7:0] out_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       overrun_o
);

    localparam int N  = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int H  = N / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Down-counter reload values; a terminal count of zero marks the sample edge.
    localparam logic [CW-1:0] N_LOAD = CW'(N - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(H - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    out_q;
    logic          valid_q;
    logic          error_q;
    logic          overrun_q;
    logic          s;

    assign s         = sync_q[1];
    assign out_o     = out_q;
    assign valid_o   = valid_q;
    assign error_o   = error_q;
    assign overrun_o = overrun_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in_i};

            // Handshake first; a frame completing on this edge overrides it below.
            if (valid_q && ready_i) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!s) begin
                            state_q <= ST_START;
                            cnt_q   <= H_LOAD;
                            bit_q   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == '0) begin
                            if (s) begin
                                state_q <= ST_IDLE;
                            end else begin
                                error_q <= 1'b0;
                                cnt_q   <= N_LOAD;
                                state_q <= ST_DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == '0) begin
                            shift_q <= {s, shift_q[7:1]};
                            cnt_q   <= N_LOAD;
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_q == '0) begin
                            if (s) begin
                                out_q   <= shift_q;
                                valid_q <= 1'b1;
                                if (valid_q && !ready_i) begin
                                    overrun_q <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                            end else begin
                                error_q <= 1'b1;
                                state_q <= ST_WAIT_HIGH;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (s) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at the nominal bit time; a monitor pops
// expected bytes from a scoreboard queue whenever the receiver presents a new byte.

module tb_uart_receiver;

    localparam int N = 208;
    localparam int H = 104;
    localparam int STOP_EDGE = 1978;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b1;
    logic       in_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] out_o;
    logic       valid_o;
    logic       error_o;
    logic       overrun_o;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   rise_cyc = 0;
    exp_t exp_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_out = 8'h00;

    uart_receiver dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .in_i      (in_i),
        .ready_i   (ready_i),
        .out_o     (out_o),
        .valid_o   (valid_o),
        .error_o   (error_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new byte is presented when valid rises or out changes under valid.
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i && valid_o && (!prev_valid || out_o != prev_out)) begin
            if (!prev_valid) rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", out_o);
            end else begin
                e = exp_q.pop_front();
                chk("mon_data", int'(out_o), int'(e.data));
                chk("mon_overrun", int'(overrun_o), int'(e.ovr));
            end
        end
        prev_valid = valid_o;
        prev_out   = out_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push(input logic [7:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovr  = o;
        exp_q.push_back(e);
    endtask

    // Full frame at the exact bit time; edge 0 is the next rising edge.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        t0 = cyc;
        in_i = 1'b0;
        idle(N);
        for (int i = 0; i < 8; i++) begin
            in_i = d[i];
            idle(N);
        end
        in_i = stop_bit;
        idle(N);
    endtask

    task automatic consume(input string name);
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
        chk({name, "_valid_clr"}, int'(valid_o), 0);
        chk({name, "_ovr_clr"}, int'(overrun_o), 0);
    endtask

    initial begin
        idle(3);
        reset_i = 1'b0;
        chk("rst_out", int'(out_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_error", int'(error_o), 0);
        chk("rst_overrun", int'(overrun_o), 0);
        idle(5);

        // Two bytes, checking the stop-edge timing on the first.
        push(8'h55, 1'b0);
        send_byte(8'h55, 1'b1);
        chk("t1_valid_edge", rise_cyc - t0, STOP_EDGE + 1);
        chk("t1_error", int'(error_o), 0);
        consume("t1a");
        push(8'hA3, 1'b0);
        send_byte(8'hA3, 1'b1);
        chk("t1_out", int'(out_o), 8'hA3);
        consume("t1b");

        // Start-bit glitch rejected.
        in_i = 1'b0;
        idle(50);
        in_i = 1'b1;
        idle(3 * N);
        chk("t2_valid", int'(valid_o), 0);
        chk("t2_error", int'(error_o), 0);
        push(8'h0F, 1'b0);
        send_byte(8'h0F, 1'b1);
        consume("t2");

        // Framing error, then cleared at the next validated start bit.
        send_byte(8'h41, 1'b0);
        in_i = 1'b1;
        idle(N);
        chk("t3_error_set", int'(error_o), 1);
        chk("t3_valid", int'(valid_o), 0);
        push(8'h42, 1'b0);
        fork
            send_byte(8'h42, 1'b1);
            begin
                idle(H + 2);
                chk("t3_error_held", int'(error_o), 1);
                idle(1);
                chk("t3_error_clr", int'(error_o), 0);
            end
        join
        chk("t3_valid_set", int'(valid_o), 1);
        chk("t3_out", int'(out_o), 8'h42);
        consume("t3");

        // Back-to-back with no consumer: overrun.
        push(8'h31, 1'b0);
        send_byte(8'h31, 1'b1);
        push(8'h32, 1'b1);
        send_byte(8'h32, 1'b1);
        chk("t4_out", int'(out_o), 8'h32);
        chk("t4_valid", int'(valid_o), 1);
        chk("t4_overrun", int'(overrun_o), 1);
        consume("t4");

        // ready on the exact stop edge of the second byte: new byte wins.
        push(8'h1F, 1'b0);
        send_byte(8'h1F, 1'b1);
        push(8'h20, 1'b0);
        fork
            send_byte(8'h20, 1'b1);
            begin
                idle(STOP_EDGE);
                ready_i = 1'b1;
                idle(1);
                ready_i = 1'b0;
            end
        join
        chk("t5_valid", int'(valid_o), 1);
        chk("t5_out", int'(out_o), 8'h20);
        chk("t5_overrun", int'(overrun_o), 0);
        consume("t5");

        // Reset mid-frame.
        push(8'h66, 1'b0);
        send_byte(8'h66, 1'b1);
        in_i = 1'b0;
        idle(2 * N);
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        chk("t6_out_rst", int'(out_o), 0);
        chk("t6_valid_rst", int'(valid_o), 0);
        chk("t6_error_rst", int'(error_o), 0);
        chk("t6_ovr_rst", int'(overrun_o), 0);
        in_i = 1'b1;
        idle(2 * N);
        push(8'h7E, 1'b0);
        send_byte(8'h7E, 1'b1);
        chk("t6_out", int'(out_o), 8'h7E);
        chk("t6_valid", int'(valid_o), 1);

        // Enable dropped mid-frame: frame discarded, flags kept, handshake live.
        in_i = 1'b0;
        idle(3 * N);
        enable_i = 1'b0;
        in_i = 1'b1;
        idle(2 * N);
        chk("t7_out_kept", int'(out_o), 8'h7E);
        chk("t7_valid_kept", int'(valid_o), 1);
        chk("t7_error_kept", int'(error_o), 0);
        consume("t7_dis");
        enable_i = 1'b1;
        idle(5);
        push(8'h7E, 1'b0);
        send_byte(8'h7E, 1'b1);
        chk("t7_out", int'(out_o), 8'h7E);
        chk("t7_valid", int'(valid_o), 1);
        consume("t7");

        idle(10);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It samples the RX pin in the middle of each bit and presents each received byte on a valid/ready handshake. It also reports framing errors and overrun to the top-level control FSM, which parses single-character commands. In the top level it runs at CLOCK_RATE = 24 MHz and BAUD_RATE = 115200.

## Interface
- CLOCK_RATE, default 24000000: clock frequency in Hz.
- BAUD_RATE, default 115200: line rate in bit/s.
- Derived constants:
  - N = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE clocks per bit, integer division (208 at the defaults).
  - H = N/2 (104).
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  receiver enable; low forces idle.
- in  in  1  asynchronous serial RX line; idles high.
- ready  in  1  consumer accepts the byte on any edge where valid&ready.
- out  out  8  last received byte.
- valid  out  1  unread byte available.
- error  out  1  framing error flag.
- overrun  out  1  a byte was overwritten before it was consumed.

## Operation
- Input path: a 2-flop synchronizer on `in`, with both flops reset to 1. The FSM uses only the synchronized value `s`.
- FSM states:
  - IDLE: if enable and s==0, go to START and clear the bit counter.
  - START: after H clocks, re-check s. If s==1 it was a glitch; return to IDLE with no flag change. If s==0, clear error and go to DATA.
  - DATA: sample s every N clocks into bit 0..7, shifting LSB first. After bit 7, go to STOP.
  - STOP: sample s after N clocks.
    - s==1: load out with the shifted byte, set valid. Set overrun if valid was already 1 and is not being consumed on this edge. Go to IDLE.
    - s==0: set error, leave out/valid unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until s==1, then go to IDLE. This blocks a false restart on a held-low line.
- Handshake:
  - valid&ready at an edge clears valid and overrun on that edge.
  - If a frame completes on the same edge, the new byte wins: valid stays 1 and overrun is not set.
  - The consumer may hold ready high permanently.
- error is sticky: it clears only when the next start bit is validated, or on reset.
- enable low: on the next edge the FSM returns to IDLE and any partial frame is discarded. out, valid, error and overrun keep their values, and the handshake still works.
- Counters are sized to hold N−1. There is no arithmetic overflow path.

## Timing
- Reset values: out=8'h00, valid=0, error=0, overrun=0, FSM in IDLE, synchronizers 1.
- Reset mid-frame aborts the frame immediately. The first edge after reset deasserts behaves as idle.
- Edge numbering: edge 0 is the first rising edge sampling raw `in`==0 while IDLE and enabled. `s` is low after edge 1, and IDLE leaves on edge 2.
  - Start re-check at edge 2+H.
  - Data bit i sampled at edge 2+H+(i+1)·N.
  - Stop sampled at edge 2+H+9·N.
  - out, valid, error and overrun update on the stop edge, visible after it. At the defaults that is edge 1978.
- After a good stop bit the FSM is back in IDLE on the same edge. A following start bit that arrives right after the stop bit is detected without loss.
- valid deasserts one edge after the handshake: visible low after the edge where valid&ready is sampled.
- Timing tolerance: at the nominal rate the received data must be correct with up to ±3% baud mismatch.

## Test plan
- Send byte 0x55, then 0xA3, at the exact bit time (N=208 clocks), with ready held low until valid.
  - out=0x55 then 0xA3.
  - valid rises at edge 1978 after the first falling edge.
  - error=0, overrun=0.
- Pulse `in` low for 50 clocks while idle.
  - No valid, no error.
  - A byte 0x0F sent afterward is received correctly.
- Send 0x41 with the stop bit driven low, then return the line high.
  - error=1, valid=0.
  - A subsequent good 0x42 clears error (at start validation) and yields out=0x42, valid=1.
- Send 0x31 and 0x32 back-to-back with ready=0.
  - out=0x32, valid=1, overrun=1.
  - Raise ready for one clock: valid=0 and overrun=0 on the next edge.
- Assert ready exactly on the stop-sampling edge of a second byte 0x20.
  - valid stays 1, out=0x20, overrun=0.
- Midway through a frame, either assert reset for one cycle or drop enable.
  - reset: outputs return to their reset values.
  - enable low: the frame is discarded and flags are unchanged.
  - In both cases a following clean byte 0x7E is received correctly.
